// File: rtl/cluster_icache_flush_sequencer.sv
// Purpose : cache-side flush responder; walks every line index and issues invalidates
//           to the tag array for the fetch ports being flushed, stalling their lookups.
// Latency : pulse in cycle t -> WALK t+2..t+1+NR_LINES, DONE t+2+NR_LINES, ready t+3+NR_LINES.
// Backpressure: inv_ready_i low holds inv_idx_o/inv_port_mask_o; each stalled cycle adds one cycle.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   flush_valid_i[N]              per-port flush request pulse (always accepted)
//   flush_ready_o[N]              1 = nothing pending or active for that port
//   inv_valid_o/inv_ready_i       invalidate handshake to the tag array
//   inv_idx_o, inv_port_mask_o    line index and ports invalidated by the request
//   lookup_stall_o[N]             blocks lookups on ports under flush
//   busy_o                        walk in progress or any request pending
//
// Optional feature: define CLUSTER_ICACHE_FLUSH_COALESCE_EN to flush all pending
// ports in a single walk instead of one port per walk chosen round-robin.
module cluster_icache_flush_sequencer #(
  parameter int NR_FETCH_PORTS = 1,
  parameter int NR_LINES       = 32,
  parameter int LINE_IDX_W     = $clog2(NR_LINES)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NR_FETCH_PORTS-1:0] flush_valid_i,
  output logic [NR_FETCH_PORTS-1:0] flush_ready_o,
  output logic                      inv_valid_o,
  input  logic                      inv_ready_i,
  output logic [LINE_IDX_W-1:0]     inv_idx_o,
  output logic [NR_FETCH_PORTS-1:0] inv_port_mask_o,
  output logic [NR_FETCH_PORTS-1:0] lookup_stall_o,
  output logic                      busy_o
);

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

  state_t                    r_state;
  logic [NR_FETCH_PORTS-1:0] r_pending;
  logic [NR_FETCH_PORTS-1:0] r_active;
  logic [LINE_IDX_W-1:0]     r_idx;

  logic [NR_FETCH_PORTS-1:0] w_grant;  // ports that start a walk when leaving IDLE
  logic [NR_FETCH_PORTS-1:0] w_clr;    // pending bits consumed this cycle

`ifdef CLUSTER_ICACHE_FLUSH_COALESCE_EN
  assign w_grant = r_pending;
`else
  localparam int PTR_W = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1;

  logic [PTR_W-1:0] r_rr_ptr;
  logic [PTR_W-1:0] w_sel;
  logic [PTR_W-1:0] w_rr_next;
  logic             w_found;

  // First pending port at or after r_rr_ptr, wrapping around.
  always_comb begin
    int unsigned p;
    p       = 0;
    w_sel   = '0;
    w_found = 1'b0;
    for (int k = 0; k < NR_FETCH_PORTS; k++) begin
      p = (int'(r_rr_ptr) + k) % NR_FETCH_PORTS;
      if (!w_found && r_pending[p]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(p);
      end
    end
  end

  assign w_rr_next = (w_sel == PTR_W'(NR_FETCH_PORTS - 1)) ? '0 : w_sel + 1'b1;
  assign w_grant   = w_found ? (NR_FETCH_PORTS'(1) << w_sel) : '0;
`endif

  assign w_clr = (r_state == IDLE) ? w_grant : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_pending <= '0;
      r_active  <= '0;
      r_idx     <= '0;
`ifndef CLUSTER_ICACHE_FLUSH_COALESCE_EN
      r_rr_ptr  <= '0;
`endif
    end else begin
      // A pulse landing on the same port being consumed re-arms it: lines
      // already swept may be refilled before the current walk finishes.
      r_pending <= (r_pending & ~w_clr) | flush_valid_i;
      case (r_state)
        IDLE: begin
          if (|r_pending) begin
            r_active <= w_grant;
            r_idx    <= '0;
`ifndef CLUSTER_ICACHE_FLUSH_COALESCE_EN
            r_rr_ptr <= w_rr_next;
`endif
            r_state  <= WALK;
          end
        end
        WALK: begin
          if (inv_ready_i) begin
            if (r_idx == LINE_IDX_W'(NR_LINES - 1)) begin
              r_state <= DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        DONE: begin
          r_active <= '0;
          r_idx    <= '0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign flush_ready_o   = ~r_pending & ~r_active;
  assign inv_valid_o     = (r_state == WALK);
  assign inv_idx_o       = r_idx;
  assign inv_port_mask_o = r_active;
  assign lookup_stall_o  = r_active;
  assign busy_o          = (r_state != IDLE) | (|r_pending);

endmodule

// File: tb/tb_cluster_icache_flush_sequencer.sv
module tb_cluster_icache_flush_sequencer;

  localparam int N = 2;
  localparam int L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] flush_valid;
  logic [N-1:0] flush_ready;
  logic         inv_valid;
  logic         inv_ready;
  logic [1:0]   inv_idx;
  logic [N-1:0] inv_mask;
  logic [N-1:0] stall;
  logic         busy;

  int tests  = 0;
  int fails  = 0;
  int hs_cnt = 0;

  // Expected invalidate stream: {idx, mask} per handshake, in order.
  logic [3:0] exp_q[$];

  cluster_icache_flush_sequencer #(
    .NR_FETCH_PORTS(N),
    .NR_LINES      (L)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_valid_i  (flush_valid),
    .flush_ready_o  (flush_ready),
    .inv_valid_o    (inv_valid),
    .inv_ready_i    (inv_ready),
    .inv_idx_o      (inv_idx),
    .inv_port_mask_o(inv_mask),
    .lookup_stall_o (stall),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are sampled mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic push_walk(input logic [1:0] m);
    for (int i = 0; i < L; i++) begin
      logic [1:0] ix;
      ix = 2'(i);
      exp_q.push_back({ix, m});
    end
  endtask

  // Scoreboard: every accepted invalidate must be the next expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && inv_valid === 1'b1 && inv_ready === 1'b1) begin
      hs_cnt++;
      chk("hs_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("hs_idx_mask", 32'({inv_idx, inv_mask}), 32'(exp_q.pop_front()));
    end
  end

`ifdef CLUSTER_ICACHE_FLUSH_COALESCE_EN
  localparam int S3_END = 7;
`else
  localparam int S3_END = 13;
`endif

  initial begin
    logic [1:0] exp_rdy;
    logic       exp_v;

    rst_n       = 1'b0;
    flush_valid = '0;
    inv_ready   = 1'b1;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_ready", 32'(flush_ready), 32'h3);
    chk("rst_inv_valid", 32'(inv_valid), 32'h0);
    chk("rst_inv_idx", 32'(inv_idx), 32'h0);
    chk("rst_mask", 32'(inv_mask), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    cyc();
    rst_n = 1'b1;

    // S1: single flush, no backpressure
    push_walk(2'b01);
    for (int c = 0; c <= 8; c++) begin
      cyc();
      flush_valid = (c == 0) ? 2'b01 : 2'b00;
      mid();
      if (c >= 1) begin
        chk("s1_ready0", 32'(flush_ready[0]), 32'(c >= 7));
        chk("s1_inv_valid", 32'(inv_valid), 32'(c >= 2 && c <= 5));
        chk("s1_stall", 32'(stall), (c >= 2 && c <= 6) ? 32'h1 : 32'h0);
        chk("s1_busy", 32'(busy), 32'(c <= 6));
        if (c >= 2 && c <= 5) chk("s1_idx", 32'(inv_idx), 32'(c - 2));
      end
    end
    chk("s1_q_empty", 32'(exp_q.size()), 32'd0);

    // S2: inv_ready low every other cycle
    hs_cnt = 0;
    push_walk(2'b01);
    for (int c = 0; c <= 12; c++) begin
      cyc();
      flush_valid = (c == 0) ? 2'b01 : 2'b00;
      inv_ready   = (c % 2 == 1);
      mid();
      if (c >= 1) chk("s2_ready0", 32'(flush_ready[0]), 32'(c >= 11));
      if (c >= 2 && c <= 9) begin
        chk("s2_inv_valid", 32'(inv_valid), 32'h1);
        chk("s2_idx_hold", 32'(inv_idx), 32'((c - 2) / 2));
      end
    end
    chk("s2_hs_cnt", 32'(hs_cnt), 32'd4);
    chk("s2_q_empty", 32'(exp_q.size()), 32'd0);

    // S6: reset asserted while the walk is at idx 1
    hs_cnt = 0;
    push_walk(2'b01);
    for (int c = 0; c <= 3; c++) begin
      cyc();
      inv_ready   = 1'b1;
      flush_valid = (c == 0) ? 2'b01 : 2'b00;
      if (c == 3) rst_n = 1'b0;
      mid();
      if (c == 2) chk("s6_idx_before", 32'(inv_idx), 32'h0);
    end
    chk("s6_ready", 32'(flush_ready), 32'h3);
    chk("s6_inv_valid", 32'(inv_valid), 32'h0);
    chk("s6_idx", 32'(inv_idx), 32'h0);
    chk("s6_mask", 32'(inv_mask), 32'h0);
    chk("s6_stall", 32'(stall), 32'h0);
    chk("s6_busy", 32'(busy), 32'h0);
    exp_q.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      cyc();
      mid();
      chk("s6_no_inv", 32'(inv_valid), 32'h0);
      chk("s6_ready_idle", 32'(flush_ready), 32'h3);
    end
    chk("s6_hs_cnt", 32'(hs_cnt), 32'd1);

    // S3: simultaneous pulses on both ports
`ifdef CLUSTER_ICACHE_FLUSH_COALESCE_EN
    push_walk(2'b11);
`else
    push_walk(2'b01);
    push_walk(2'b10);
`endif
    for (int c = 0; c <= S3_END; c++) begin
      cyc();
      flush_valid = (c == 0) ? 2'b11 : 2'b00;
      mid();
`ifdef CLUSTER_ICACHE_FLUSH_COALESCE_EN
      exp_rdy = (c >= 7) ? 2'b11 : 2'b00;
      exp_v   = (c >= 2 && c <= 5);
`else
      exp_rdy = (c >= 13) ? 2'b11 : ((c >= 7) ? 2'b01 : 2'b00);
      exp_v   = (c >= 2 && c <= 5) || (c >= 8 && c <= 11);
`endif
      if (c >= 1) begin
        chk("s3_ready", 32'(flush_ready), 32'(exp_rdy));
        chk("s3_inv_valid", 32'(inv_valid), 32'(exp_v));
      end
    end
    chk("s3_q_empty", 32'(exp_q.size()), 32'd0);

    // S4: re-flush port0 while its walk is at idx 2
    push_walk(2'b01);
    push_walk(2'b01);
    for (int c = 0; c <= 13; c++) begin
      cyc();
      flush_valid = (c == 0 || c == 4) ? 2'b01 : 2'b00;
      mid();
      if (c >= 1) chk("s4_ready0", 32'(flush_ready[0]), 32'(c >= 13));
      if (c == 4) chk("s4_idx_at_pulse", 32'(inv_idx), 32'h2);
    end
    chk("s4_q_empty", 32'(exp_q.size()), 32'd0);

`ifndef CLUSTER_ICACHE_FLUSH_COALESCE_EN
    // S5: port0 re-pulsed during every walk; port1 must still get its turns
    push_walk(2'b01);
    push_walk(2'b10);
    push_walk(2'b01);
    push_walk(2'b10);
    for (int c = 0; c <= 25; c++) begin
      cyc();
      case (c)
        0, 3, 9: flush_valid = 2'b01;
        1, 15:   flush_valid = 2'b10;
        default: flush_valid = 2'b00;
      endcase
      mid();
      if (c == 8)  chk("s5_second_walk_port1", 32'(stall), 32'h2);
      if (c == 14) chk("s5_third_walk_port0", 32'(stall), 32'h1);
      if (c == 24) chk("s5_ready_c24", 32'(flush_ready), 32'h1);
      if (c == 25) chk("s5_ready_c25", 32'(flush_ready), 32'h3);
    end
    chk("s5_q_empty", 32'(exp_q.size()), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
